paddle_ai_engine: RTL and testbench

PADDLE_AI_ENGINE -- requirements
Module: paddle_ai_engine

---
 rtl/paddle_ai_pkg.sv | 27 ++
 rtl/ball_predictor.sv | 41 ++++
 rtl/paddle_ai_engine.sv | 157 +++++++++++++++
 tb/tb_paddle_ai_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_ai_pkg.sv
// rtl/paddle_ai_pkg.sv - shared FSM, digit and action encodings for the paddle AI engine
package paddle_ai_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PREDICT = 3'd1,
      ENCODE  = 3'd2,
      FETCH   = 3'd3,
      WAIT    = 3'd4,
      OUT     = 3'd5
   } state_t;

   localparam logic [1:0] DIG_HOLD = 2'd0;
   localparam logic [1:0] DIG_UP   = 2'd1;
   localparam logic [1:0] DIG_DOWN = 2'd2;

   localparam logic [2:0] ACTION_NONE   = 3'd0;
   localparam logic [2:0] ACTION_OFFSET = 3'd1;

   function automatic longint unsigned pow3(input int e);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < e; i++) r = r * 3;
      return r;
   endfunction

endpackage

// File: rtl/ball_predictor.sv
// rtl/ball_predictor.sv - linear lookahead of one ball with wall clamp/reflection and saturation
module ball_predictor #(
   parameter int COORD_W   = 11,
   parameter int LOOKAHEAD = 3,
   parameter int FIELD_H   = 480
) (
   input  logic signed [COORD_W-1:0] x,
   input  logic signed [COORD_W-1:0] y,
   input  logic signed [COORD_W-1:0] vx,
   input  logic signed [COORD_W-1:0] vy,
   output logic signed [COORD_W-1:0] px,
   output logic signed [COORD_W-1:0] py
);

   localparam int EW = COORD_W + 3;
   localparam logic signed [EW-1:0] LA   = EW'(LOOKAHEAD);
   localparam logic signed [EW-1:0] FH   = EW'(FIELD_H);
   localparam logic signed [EW-1:0] FH2  = EW'(2 * FIELD_H);
   localparam logic signed [EW-1:0] VMAX = EW'((2 ** (COORD_W - 1)) - 1);
   localparam logic signed [EW-1:0] VMIN = -VMAX - EW'(1);

   logic signed [EW-1:0] ex, ey, ry;

   function automatic logic signed [COORD_W-1:0] sat(input logic signed [EW-1:0] v);
      if (v > VMAX)      return VMAX[COORD_W-1:0];
      else if (v < VMIN) return VMIN[COORD_W-1:0];
      else               return v[COORD_W-1:0];
   endfunction

   always_comb begin
      ex = EW'(x) + LA * EW'(vx);
      ey = EW'(y) + LA * EW'(vy);
      // single bounce only: a ball far past the bottom wall may still land negative
      if (ey < 0)       ry = -ey;
      else if (ey > FH) ry = FH2 - ey;
      else              ry = ey;
      px = (ex < 0) ? '0 : sat(ex);
      py = sat(ry);
   end

endmodule

// File: rtl/paddle_ai_engine.sv
// rtl/paddle_ai_engine.sv - predicts balls, sorts by x, encodes base-3 state and looks up a policy ROM
module paddle_ai_engine #(
   parameter int N_BALLS   = 5,
   parameter int N_PADDLES = 2,
   parameter int COORD_W   = 11,
   parameter int LOOKAHEAD = 3,
   parameter int HALF_PAD  = 40,
   parameter int FIELD_H   = 480,
   parameter int ROM_LAT   = 1,
   parameter int ADDR_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [N_BALLS*COORD_W-1:0]     ball_pos_x,
   input  logic [N_BALLS*COORD_W-1:0]     ball_pos_y,
   input  logic [N_BALLS*COORD_W-1:0]     ball_vel_x,
   input  logic [N_BALLS*COORD_W-1:0]     ball_vel_y,
   input  logic [N_PADDLES*COORD_W-1:0]   paddle_pos_y,
   output logic                           rom_en,
   output logic [ADDR_W-1:0]              rom_addr,
   input  logic [1:0]                     rom_data,
   output logic                           busy,
   output logic                           done,
   output logic [2:0]                     action
);
   import paddle_ai_pkg::*;

   localparam int CNT_MAX = (N_BALLS > ROM_LAT) ? N_BALLS : ROM_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int EW      = COORD_W + 2;
   localparam logic [CNT_W-1:0] LAST_BALL = CNT_W'(N_BALLS - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ROM_LAT - 1);
   localparam logic signed [EW-1:0] HP    = EW'(HALF_PAD);

   if (pow3(N_BALLS * N_PADDLES) > (64'd1 << ADDR_W)) begin : g_addr_check
      $error("policy state space does not fit in ADDR_W address bits");
   end

   state_t                       state, state_nx;
   logic [CNT_W-1:0]             cnt;
   logic [ADDR_W-1:0]            acc, acc_nx, weight, weight_nx;
   logic [N_BALLS*COORD_W-1:0]   sx, sy, svx, svy;
   logic [N_PADDLES*COORD_W-1:0] spad;
   logic signed [COORD_W-1:0]    key [N_BALLS];
   logic signed [COORD_W-1:0]    ly  [N_BALLS];
   logic signed [COORD_W-1:0]    pred_x, pred_y;
   logic signed [EW-1:0]         slot_y, pad_v;
   logic [1:0]                   dig;
   int                           ins_pos;

   assign rom_addr = acc;

   ball_predictor #(
      .COORD_W   (COORD_W),
      .LOOKAHEAD (LOOKAHEAD),
      .FIELD_H   (FIELD_H)
   ) u_pred (
      .x  (sx [int'(cnt)*COORD_W +: COORD_W]),
      .y  (sy [int'(cnt)*COORD_W +: COORD_W]),
      .vx (svx[int'(cnt)*COORD_W +: COORD_W]),
      .vy (svy[int'(cnt)*COORD_W +: COORD_W]),
      .px (pred_x),
      .py (pred_y)
   );

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      done     = 1'b0;
      rom_en   = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = PREDICT;
         PREDICT: if (cnt == LAST_BALL) state_nx = ENCODE;
         ENCODE:  if (cnt == LAST_BALL) state_nx = FETCH;
         FETCH: begin
            rom_en   = 1'b1;
            state_nx = WAIT;
         end
         WAIT:    if (cnt == LAST_WAIT) state_nx = OUT;
         OUT: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // equal keys land after existing entries, so earlier balls keep precedence
   always_comb begin
      ins_pos = 0;
      for (int j = 0; j < N_BALLS; j++)
         if (j < int'(cnt) && key[j] <= pred_x) ins_pos = ins_pos + 1;
   end

   always_comb begin
      acc_nx    = acc;
      weight_nx = weight;
      slot_y    = EW'(ly[cnt]);
      pad_v     = '0;
      dig       = DIG_HOLD;
      for (int p = 0; p < N_PADDLES; p++) begin
         pad_v = EW'($signed(spad[p*COORD_W +: COORD_W]));
         if (slot_y > pad_v + HP)      dig = DIG_UP;
         else if (slot_y < pad_v - HP) dig = DIG_DOWN;
         else                          dig = DIG_HOLD;
         acc_nx    = acc_nx + ADDR_W'(dig) * weight_nx;
         weight_nx = weight_nx + (weight_nx << 1);
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         sx   <= ball_pos_x;
         sy   <= ball_pos_y;
         svx  <= ball_vel_x;
         svy  <= ball_vel_y;
         spad <= paddle_pos_y;
      end
      if (state == PREDICT) begin
         for (int j = N_BALLS - 1; j >= 1; j--)
            if (j > ins_pos) begin
               key[j] <= key[j-1];
               ly[j]  <= ly[j-1];
            end
         for (int j = 0; j < N_BALLS; j++)
            if (j == ins_pos) begin
               key[j] <= pred_x;
               ly[j]  <= pred_y;
            end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         weight <= '0;
         action <= ACTION_NONE;
      end else begin
         state <= state_nx;
         if (state != state_nx)  cnt <= '0;
         else if (state != IDLE) cnt <= cnt + CNT_W'(1);
         if (state == IDLE && start) begin
            acc    <= '0;
            weight <= ADDR_W'(1);
         end else if (state == ENCODE) begin
            acc    <= acc_nx;
            weight <= weight_nx;
         end
         if (state == WAIT && state_nx == OUT)
            action <= {1'b0, rom_data} + ACTION_OFFSET;
      end
   end

endmodule

// File: tb/tb_paddle_ai_engine.sv
// tb/tb_paddle_ai_engine.sv - scoreboard bench for paddle_ai_engine (default and reduced parameter sets)
module tb_paddle_ai_engine;

   typedef struct {
      logic [15:0] addr;
      logic [2:0]  act;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic        start = 1'b0;
   logic [54:0] bpx, bpy, bvx, bvy;
   logic [21:0] pad;
   logic        rom_en, busy, done;
   logic [15:0] rom_addr;
   logic [1:0]  rom_data, rom_val = 2'd0;
   logic [2:0]  action;
   logic        rv1 = 1'b0;

   logic        s_start = 1'b0;
   logic [32:0] s_bpx, s_bpy, s_bvx, s_bvy;
   logic [10:0] s_pad;
   logic        s_rom_en, s_busy, s_done;
   logic [15:0] s_rom_addr;
   logic [1:0]  s_rom_data, s_rom_val = 2'd0;
   logic [2:0]  s_action;
   logic [1:0]  srv = 2'b00;

   exp_t exp_q[$];
   exp_t s_exp_q[$];
   exp_t me, sme;
   int   en_cnt = 0, s_en_cnt = 0, done_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM models return the complement of the programmed value outside the valid window
   always @(posedge clk) rv1 <= rom_en;
   always @(posedge clk) srv <= {srv[0], s_rom_en};
   assign rom_data   = rv1    ? rom_val   : ~rom_val;
   assign s_rom_data = srv[1] ? s_rom_val : ~s_rom_val;

   paddle_ai_engine u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ball_pos_x(bpx), .ball_pos_y(bpy), .ball_vel_x(bvx), .ball_vel_y(bvy),
      .paddle_pos_y(pad), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .busy(busy), .done(done), .action(action)
   );

   paddle_ai_engine #(.N_BALLS(3), .N_PADDLES(1), .ROM_LAT(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start),
      .ball_pos_x(s_bpx), .ball_pos_y(s_bpy), .ball_vel_x(s_bvx), .ball_vel_y(s_bvy),
      .paddle_pos_y(s_pad), .rom_en(s_rom_en), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
      .busy(s_busy), .done(s_done), .action(s_action)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   task automatic set_ball(input int i, input int x, input int y, input int vx, input int vy);
      bpx[i*11 +: 11] = 11'(x);
      bpy[i*11 +: 11] = 11'(y);
      bvx[i*11 +: 11] = 11'(vx);
      bvy[i*11 +: 11] = 11'(vy);
   endtask

   task automatic set_sball(input int i, input int x, input int y);
      s_bpx[i*11 +: 11] = 11'(x);
      s_bpy[i*11 +: 11] = 11'(y);
      s_bvx[i*11 +: 11] = 11'd0;
      s_bvy[i*11 +: 11] = 11'd0;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 5; i++) set_ball(i, 0, 240, 0, 0);
      pad = {11'd240, 11'd240};
   endtask

   task automatic wait_done(input bit sel);
      int k;
      k = 0;
      while (!(sel ? s_done : done) && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", sel ? s_done : done, 1);
      @(negedge clk);
   endtask

   task automatic run_op(input bit sel, input logic [15:0] a, input logic [2:0] act,
                         input logic [1:0] rv);
      exp_t e;
      @(negedge clk);
      e.addr = a;
      e.act  = act;
      e.t0   = cyc;
      if (sel) begin
         s_rom_val = rv;
         e.lat     = 10;
         s_exp_q.push_back(e);
         s_start   = 1'b1;
      end else begin
         rom_val = rv;
         e.lat   = 13;
         exp_q.push_back(e);
         start   = 1'b1;
      end
      @(negedge clk);
      start   = 1'b0;
      s_start = 1'b0;
      wait_done(sel);
   endtask

   always @(negedge clk) begin
      if (!rst_n) en_cnt = 0;
      else begin
         if (rom_en) en_cnt++;
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done got=1 want=0 (cycle %0d)", cyc);
            end else begin
               me = exp_q.pop_front();
               chk("rom_addr", rom_addr, me.addr);
               chk("action", action, me.act);
               chk("done_latency", cyc - me.t0, me.lat);
               chk("rom_en_pulses", en_cnt, 1);
            end
            en_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) s_en_cnt = 0;
      else begin
         if (s_rom_en) s_en_cnt++;
         if (s_done) begin
            if (s_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL s_unexpected_done got=1 want=0 (cycle %0d)", cyc);
            end else begin
               sme = s_exp_q.pop_front();
               chk("s_rom_addr", s_rom_addr, sme.addr);
               chk("s_addr_bound", s_rom_addr <= 16'd26, 1);
               chk("s_action", s_action, sme.act);
               chk("s_done_latency", cyc - sme.t0, sme.lat);
               chk("s_rom_en_pulses", s_en_cnt, 1);
            end
            s_en_cnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, d0;
      clear_inputs();
      for (int i = 0; i < 3; i++) set_sball(i, 0, 240);
      s_pad = 11'd240;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_action", action, 0);
      rst_n = 1'b1;

      clear_inputs();
      run_op(0, 16'd0, 3'd3, 2'd2);

      clear_inputs();
      set_ball(0, 0, 5, 0, -4);
      run_op(0, 16'd8, 3'd2, 2'd1);

      clear_inputs();
      set_ball(0, 300, 400, 0, 0);
      for (int i = 1; i < 5; i++) set_ball(i, i - 1, 240, 0, 0);
      run_op(0, 16'd26244, 3'd1, 2'd0);

      // snapshot isolation and ignored starts at cycles 3 and 13
      pad = {11'd400, 11'd100};
      for (int i = 0; i < 5; i++) set_ball(i, i * 10, 240, 0, 0);
      set_ball(3, 30, 470, -20, 10);
      @(negedge clk);
      rom_val = 2'd3;
      t0 = cyc;
      exp_q.push_back('{addr: 16'd51640, act: 3'd4, lat: 13, t0: t0});
      d0 = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) set_ball(i, 0, 0, 0, 0);
      pad = '0;
      repeat (2) @(negedge clk);
      chk("busy_mid", busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("done_at_13", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("single_done", done_cnt - d0, 1);

      // reset in the middle of an operation
      clear_inputs();
      @(negedge clk);
      exp_q.push_back('{addr: 16'd0, act: 3'd3, lat: 13, t0: cyc});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_action", action, 0);
      chk("midrst_rom_addr", rom_addr, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
      set_ball(0, 0, 5, 0, -4);
      run_op(0, 16'd8, 3'd2, 2'd1);

      set_sball(0, 0, 400);
      set_sball(1, 0, 100);
      set_sball(2, 0, 240);
      run_op(1, 16'd7, 3'd2, 2'd1);
      for (int i = 0; i < 3; i++) set_sball(i, 0, 100);
      run_op(1, 16'd26, 3'd3, 2'd2);

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("s_queue_empty", s_exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
